// File: rtl/score_keeper.sv
// Pong score/rally sequencer: IDLE -> SERVE countdown -> PLAY -> OVER; all outputs registered, 1-cycle response.
// No backpressure (pulse inputs are consumed on the sampling edge). Optional winner blink under SCORE_BLINK_EN.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_left,
  input  logic       point_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic       show_left,
  output logic       show_right
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);
  localparam logic [9:0] PAUSE_LAST = 10'(PAUSE_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] sl_q, sl_d, sr_q, sr_d;
  logic [3:0] sl_inc, sr_inc;
  logic       run_q, run_d;
  logic       dir_q, dir_d;
  logic       over_q, over_d;
  logic       win_q, win_d;

  assign sl_inc = sl_q + 4'd1;
  assign sr_inc = sr_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    run_d   = run_q;
    dir_d   = dir_q;
    over_d  = over_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SERVE;
          sl_d    = '0;
          sr_d    = '0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            run_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      S_PLAY: begin
        // Simultaneous points are a glitch and both are dropped.
        if (point_left && !point_right) begin
          sl_d  = sl_inc;
          dir_d = 1'b1;
          run_d = 1'b0;
          if (sl_inc == WIN_Q) begin
            state_d = S_OVER;
            over_d  = 1'b1;
            win_d   = 1'b0;
          end else begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end
        end else if (point_right && !point_left) begin
          sr_d  = sr_inc;
          dir_d = 1'b0;
          run_d = 1'b0;
          if (sr_inc == WIN_Q) begin
            state_d = S_OVER;
            over_d  = 1'b1;
            win_d   = 1'b1;
          end else begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_SERVE;
          sl_d    = '0;
          sr_d    = '0;
          cnt_d   = '0;
          dir_d   = 1'b0;
          over_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign ball_run    = run_q;
  assign serve_dir   = dir_q;
  assign game_over   = over_q;
  assign winner      = win_q;

`ifdef SCORE_BLINK_EN
  logic [3:0] blink_q, blink_d;
  logic       shl_q, shl_d, shr_q, shr_d;

  // Blink counter only runs while staying in OVER; any other edge clears it.
  always_comb begin
    blink_d = '0;
    shl_d   = 1'b1;
    shr_d   = 1'b1;
    if (state_q == S_OVER && state_d == S_OVER) begin
      blink_d = blink_q;
      shl_d   = shl_q;
      shr_d   = shr_q;
      if (frame_tick) begin
        blink_d = blink_q + 4'd1;
        if (blink_q == 4'hF) begin
          if (win_q) shr_d = !shr_q;
          else       shl_d = !shl_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= '0;
      shl_q   <= 1'b1;
      shr_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
    end
  end

  assign show_left  = shl_q;
  assign show_right = shr_q;
`else
  assign show_left  = 1'b1;
  assign show_right = 1'b1;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized bench for score_keeper with a scoreboard queue fed by a game-rules model.
module tb_score_keeper;

  localparam int WIN   = 3;
  localparam int PAUSE = 20;
  localparam int NCYC  = 12000;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, point_left, point_right;
  logic [3:0] score_left, score_right;
  logic       ball_run, serve_dir, game_over, winner, show_left, show_right;

  score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PAUSE)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .point_left(point_left), .point_right(point_right),
    .score_left(score_left), .score_right(score_right),
    .ball_run(ball_run), .serve_dir(serve_dir), .game_over(game_over),
    .winner(winner), .show_left(show_left), .show_right(show_right)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sl;
    logic [3:0] sr;
    logic       run;
    logic       dir;
    logic       over;
    logic       win;
    logic       shl;
    logic       shr;
  } exp_t;

  exp_t exp_q[$];
  int   npass = 0;
  int   ntotal = 0;

  task automatic chk(input string name, input int act, input int req);
    ntotal++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".score_left"},  int'(score_left),  int'(e.sl));
    chk({tag, ".score_right"}, int'(score_right), int'(e.sr));
    chk({tag, ".ball_run"},    int'(ball_run),    int'(e.run));
    chk({tag, ".serve_dir"},   int'(serve_dir),   int'(e.dir));
    chk({tag, ".game_over"},   int'(game_over),   int'(e.over));
    chk({tag, ".winner"},      int'(winner),      int'(e.win));
    chk({tag, ".show_left"},   int'(show_left),   int'(e.shl));
    chk({tag, ".show_right"},  int'(show_right),  int'(e.shr));
  endtask

  // Game model: phase of the match, ticks seen in this serve, ticks seen since the match ended.
  typedef enum int {G_IDLE, G_SERVE, G_PLAY, G_OVER} phase_t;
  phase_t g_phase;
  int g_left, g_right, g_serve_ticks, g_over_ticks;
  bit g_toward_right, g_right_won;

  function automatic exp_t predict();
    exp_t e;
    bit   lit;
    e.sl   = 4'(g_left);
    e.sr   = 4'(g_right);
    e.run  = (g_phase == G_PLAY);
    e.dir  = g_toward_right;
    e.over = (g_phase == G_OVER);
    e.win  = g_right_won;
    e.shl  = 1'b1;
    e.shr  = 1'b1;
`ifdef SCORE_BLINK_EN
    lit = ((g_over_ticks / 16) % 2) == 0;
    if (g_phase == G_OVER) begin
      if (g_right_won) e.shr = lit;
      else             e.shl = lit;
    end
`endif
    return e;
  endfunction

  task automatic model_reset();
    g_phase = G_IDLE; g_left = 0; g_right = 0; g_serve_ticks = 0; g_over_ticks = 0;
    g_toward_right = 0; g_right_won = 0;
  endtask

  task automatic new_match();
    g_phase = G_SERVE; g_left = 0; g_right = 0; g_serve_ticks = 0; g_toward_right = 0;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit tk, input bit pl, input bit pr);
    if (rst) begin
      model_reset();
      return;
    end
    case (g_phase)
      G_IDLE: if (st) new_match();
      G_SERVE: if (tk) begin
        g_serve_ticks++;
        if (g_serve_ticks == PAUSE) g_phase = G_PLAY;
      end
      G_PLAY: if (pl != pr) begin
        if (pl) begin g_left++;  g_toward_right = 1; end
        else    begin g_right++; g_toward_right = 0; end
        if (g_left == WIN || g_right == WIN) begin
          g_phase = G_OVER; g_right_won = pr; g_over_ticks = 0;
        end else begin
          g_phase = G_SERVE; g_serve_ticks = 0;
        end
      end
      default: begin
        if (st) new_match();
        else if (tk) g_over_ticks++;
      end
    endcase
  endtask

  // Monitor: one expected response per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("edge", e);
      end
    end
  end

  initial begin
    bit r_rst, r_st, r_tk, r_pl, r_pr;
    int wins = 0, blinks = 0;
    reset = 1'b1; frame_tick = 0; start = 0; point_left = 0; point_right = 0;
    model_reset();
    #1;
    chk_all("reset_init", predict());

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      r_rst = (c < 2) || ($urandom_range(0, 599) == 0);
      r_st  = ($urandom_range(0, 79) == 0);
      r_tk  = ($urandom_range(0, 1) == 0);
      r_pl  = ($urandom_range(0, 6) == 0);
      r_pr  = ($urandom_range(0, 6) == 0);
      reset = r_rst; start = r_st; frame_tick = r_tk; point_left = r_pl; point_right = r_pr;
      if (r_rst && c >= 2) begin
        // Reset lands mid-cycle: outputs must clear before any clock edge.
        model_reset();
        #1;
        chk_all("async_reset", predict());
      end
      model_step(r_rst, r_st, r_tk, r_pl, r_pr);
      if (g_phase == G_OVER && g_over_ticks == 0) wins++;
      if (g_phase == G_OVER && g_over_ticks == 16) blinks++;
      exp_q.push_back(predict());
    end

    @(negedge clk);
    reset = 0; start = 0; frame_tick = 0; point_left = 0; point_right = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    if (wins == 0) $display("note: no match reached the winning score");
    if (blinks == 0) $display("note: no match stayed over for 16 ticks");
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-level score and rally sequencer for Pong. Counts points for the left and right players from ball-logic events, runs the serve countdown between rallies, and detects the end of the match. Its registered score outputs drive the two score display components. `ball_run` and `serve_dir` gate the ball motion logic.

## Interface

Parameters:
- `WIN_SCORE`, default 9: score that ends the match. Legal range is 1..9, so a score always fits one display digit.
- `PAUSE_FRAMES`, default 60: number of `frame_tick` pulses in the serve countdown. Legal range is 1..1023.

Ports:
- `clk`  in  1  system clock (pixel clock domain)
- `reset`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per video frame
- `start`  in  1  one-cycle pulse, start/restart request (debounced upstream)
- `point_left`  in  1  one-cycle pulse: left player scored (ball passed the right wall)
- `point_right`  in  1  one-cycle pulse: right player scored
- `score_left`  out  4  left score, 0..WIN_SCORE
- `score_right`  out  4  right score, 0..WIN_SCORE
- `ball_run`  out  1  ball may move; 1 only in PLAY
- `serve_dir`  out  1  serve direction: 1 = toward right player, 0 = toward left
- `game_over`  out  1  1 in OVER
- `winner`  out  1  0 = left won, 1 = right won; valid while `game_over` = 1
- `show_left`, `show_right`  out  1 each  score digit visibility (see Configuration)

## Operation

- States: IDLE, SERVE, PLAY, OVER.
- Reset values (asynchronous, while `reset` = 1): state IDLE, both scores 0, frame counter 0, `ball_run` 0, `serve_dir` 0, `game_over` 0, `winner` 0, `show_left` 1, `show_right` 1.
- IDLE:
  - `start` → clear both scores, clear the frame counter, set `serve_dir` = 0, go to SERVE.
  - All other inputs are ignored.
- SERVE:
  - Each `frame_tick` increments the frame counter.
  - When a tick arrives with the counter = PAUSE_FRAMES−1 → go to PLAY and clear the counter.
  - `start`, `point_left` and `point_right` are ignored.
- PLAY:
  - `point_left` alone → `score_left` +1 and `serve_dir` = 1 (serve toward the player who conceded).
  - `point_right` alone → `score_right` +1 and `serve_dir` = 0.
  - After a point: if the new score equals WIN_SCORE → go to OVER with `winner` set to the scorer. Otherwise go to SERVE with the counter cleared.
  - `point_left` and `point_right` asserted in the same cycle → both dropped (treated as a glitch), stay in PLAY.
  - `start` is ignored.
- OVER:
  - Scores are frozen.
  - `start` → clear scores, clear counter, set `serve_dir` = 0, go to SERVE. `winner` holds its value until OVER is next entered.
- Arithmetic:
  - Scores are 4-bit unsigned and never exceed WIN_SCORE. No wrap is possible.
  - The frame counter is 10-bit and compared for equality only.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- A point pulse sampled at edge N updates the score, `serve_dir`, the state and `ball_run` at edge N; the new values are visible in cycle N+1.
- `ball_run` rises on the same edge that enters PLAY. It falls on the same edge that consumes a point.
- Serve countdown: exactly PAUSE_FRAMES `frame_tick` pulses are counted from SERVE entry before PLAY is entered. A tick coinciding with the entry edge is not counted.
- A `start` in IDLE or OVER takes effect in 1 cycle. Back-to-back `start` pulses in SERVE do not restart the countdown.
- A `reset` assertion at any point (mid-countdown, mid-rally, in OVER) returns all state to the reset values immediately, with no clock required.

## Configuration

- `SCORE_BLINK_EN` defined:
  - In OVER, the winner's visibility output toggles every 16 `frame_tick` pulses, driven by a 4-bit blink counter cleared on OVER entry.
  - The loser's visibility output stays 1.
  - Both visibility outputs are forced to 1 in every other state.
- `SCORE_BLINK_EN` undefined: `show_left` = `show_right` = 1 at all times, and no blink counter is built.

## Test plan

- Reset, then `start`, then 60 `frame_tick` pulses → `ball_run` = 0 after tick 59 and 1 immediately after tick 60; both scores 0; `serve_dir` = 0.
- In PLAY, pulse `point_left` → next cycle `score_left` = 1, `ball_run` = 0, `serve_dir` = 1, state SERVE. Then 60 ticks → PLAY again.
- With WIN_SCORE = 3, the right player scores 3 times → `score_right` = 3, `game_over` = 1, `winner` = 1. A further `point_right` leaves `score_right` = 3.
- `point_left` and `point_right` in the same PLAY cycle → scores unchanged and `ball_run` stays 1. Point pulses during SERVE → no effect.
- Assert `reset` at countdown tick 30 with `score_left` = 2 → all outputs return to reset values asynchronously. After release, the block stays in IDLE until `start`.
- With `SCORE_BLINK_EN` and the left player winning → `show_left` toggles after ticks 16, 32, 48 while `show_right` = 1. Then `start` → both 1 and scores 0.
